// File: rtl/bus_ram_responder.sv
// Bus responder: word-addressed RAM plus control registers, programmable grant delay,
// 1-cycle registered read data, saturating write counter with level watermark interrupt.
module bus_ram_responder #(
  parameter int DEPTH     = 64,
  parameter int GRANT_DLY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_req,
  input  logic        M_wr,
  input  logic [7:0]  M_address,
  input  logic [31:0] M_dout,
  output logic        M_grant,
  output logic [31:0] M_din,
  output logic        interrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] ADDR_STATUS = 8'h40;
  localparam logic [7:0] ADDR_WMARK  = 8'h4A;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h4B;
  localparam logic [7:0] ADDR_CLEAR  = 8'h4C;
  localparam logic [7:0] RAM_LIMIT   = 8'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GRANTED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_nxt;
  logic        r_grant;

  logic [31:0] r_mem [DEPTH];
  logic [7:0]  r_wcnt;
  logic [7:0]  r_wmark;
  logic        r_irq_en;
  logic        r_irq;
  logic [31:0] r_din;

  logic          w_access;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_ram_hit;
  logic [AW-1:0] w_ram_idx;
  logic          w_irq_pending;
  logic [31:0]   w_rd_dat;

  // ---------------- grant FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_grant    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_grant    <= (w_state_nxt == ST_GRANTED);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (!M_req) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (GRANT_DLY == 0) begin
            w_state_nxt = ST_GRANTED;
          end else begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = 4'(GRANT_DLY - 1);
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            w_state_nxt = ST_GRANTED;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 4'd1;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign M_grant = r_grant;

  // ---------------- access decode ----------------
  // A reset edge never performs an access, even if grant was still high.
  assign w_access  = M_req & r_grant & ~reset;
  assign w_wr_acc  = w_access & M_wr;
  assign w_rd_acc  = w_access & ~M_wr;
  assign w_ram_hit = (M_address < RAM_LIMIT);
  assign w_ram_idx = M_address[AW-1:0];

  assign w_irq_pending = (r_wmark != 8'd0) && (r_wcnt >= r_wmark);

  always_comb begin
    w_rd_dat = 32'h0;
    if (w_ram_hit) begin
      w_rd_dat = r_mem[w_ram_idx];
    end else begin
      case (M_address)
        ADDR_STATUS: w_rd_dat = {23'b0, w_irq_pending, r_wcnt};
        ADDR_WMARK:  w_rd_dat = {24'b0, r_wmark};
        ADDR_IRQ_EN: w_rd_dat = {31'b0, r_irq_en};
        default:     w_rd_dat = 32'h0;
      endcase
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_ram_hit) begin
      r_mem[w_ram_idx] <= M_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt   <= 8'd0;
      r_wmark  <= 8'd0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
      r_din    <= 32'h0;
    end else begin
      if (w_wr_acc && (M_address == ADDR_WMARK)) begin
        r_wmark <= M_dout[7:0];
      end
      if (w_wr_acc && (M_address == ADDR_IRQ_EN)) begin
        r_irq_en <= M_dout[0];
      end
      if (w_wr_acc && (M_address == ADDR_CLEAR)) begin
        r_wcnt <= 8'd0;
      end else if (w_wr_acc && w_ram_hit && (r_wcnt != 8'hFF)) begin
        r_wcnt <= r_wcnt + 8'd1;
      end
      if (w_rd_acc) begin
        r_din <= w_rd_dat;
      end
      // Sampled from current register state, so it lags the triggering write by one edge.
      r_irq <= r_irq_en & w_irq_pending;
    end
  end

  assign M_din     = r_din;
  assign interrupt = r_irq;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: directed scenarios plus random traffic against a
// behavioural model; read data flows through a scoreboard queue to a monitor.
module tb_bus_ram_responder;

  localparam int DEPTH = 64;
  localparam int GDLY  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        M_req = 1'b0;
  logic        M_wr = 1'b0;
  logic [7:0]  M_address = 8'h0;
  logic [31:0] M_dout = 32'h0;
  logic        M_grant, interrupt;
  logic [31:0] M_din;
  logic        M_grant0, interrupt0;
  logic [31:0] M_din0;

  always #5 clk = ~clk;

  bus_ram_responder #(.DEPTH(DEPTH), .GRANT_DLY(GDLY)) u_dut (
    .clk(clk), .reset(reset), .M_req(M_req), .M_wr(M_wr),
    .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din), .interrupt(interrupt)
  );

  // Zero-delay variant, only its grant timing is checked.
  bus_ram_responder #(.DEPTH(DEPTH), .GRANT_DLY(0)) u_dut0 (
    .clk(clk), .reset(reset), .M_req(M_req), .M_wr(M_wr),
    .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant0), .M_din(M_din0), .interrupt(interrupt0)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  int          m_wcnt = 0;
  int          m_wmark = 0;
  bit          m_irq_en = 1'b0;
  int          m_run = 0;       // consecutive edges with M_req sampled high since reset/drop
  bit          m_grant = 1'b0;  // expected grant after last edge
  logic [31:0] exp_q [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pending();
    return (m_wmark != 0) && (m_wcnt >= m_wmark);
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] v;
    v = 32'h0;
    if (a < DEPTH) v = m_mem[a];
    else if (a == 'h40) v = {23'b0, m_pending(), 8'(m_wcnt)};
    else if (a == 'h4A) v = 32'(m_wmark);
    else if (a == 'h4B) v = {31'b0, m_irq_en};
    return v;
  endfunction

  // One clock of stimulus; model advances with the edge, then grant/irq are checked.
  task automatic tick(bit rst, bit req, bit wr, int addr, logic [31:0] data);
    bit acc, exp_irq;
    @(negedge clk);
    reset = rst; M_req = req; M_wr = wr; M_address = 8'(addr); M_dout = data;
    acc     = !rst && req && m_grant;
    exp_irq = !rst && m_irq_en && m_pending();
    if (acc && !wr) exp_q.push_back(m_read(addr));
    @(posedge clk);
    if (rst) begin
      m_wcnt = 0; m_wmark = 0; m_irq_en = 1'b0;
    end else if (acc && wr) begin
      if (addr < DEPTH) begin
        m_mem[addr] = data;
        if (m_wcnt < 255) m_wcnt++;
      end else if (addr == 'h4A) m_wmark = int'(data[7:0]);
      else if (addr == 'h4B) m_irq_en = data[0];
      else if (addr == 'h4C) m_wcnt = 0;
    end
    m_run   = (rst || !req) ? 0 : m_run + 1;
    m_grant = (m_run >= GDLY + 1);
    #1;
    check("grant", {31'b0, M_grant}, {31'b0, m_grant});
    check("grant_dly0", {31'b0, M_grant0}, {31'b0, m_run >= 1});
    check("interrupt", {31'b0, interrupt}, {31'b0, exp_irq});
  endtask

  task automatic acquire();
    while (!m_grant) tick(1'b0, 1'b1, 1'b0, 'h41, 32'h0);
  endtask

  task automatic wr(int a, logic [31:0] d);
    tick(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(int a);
    tick(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  // Monitor: M_din must carry the popped expectation after a read access, else hold.
  logic        mon_rd, mon_rs;
  logic [31:0] last_din = 32'h0;
  always @(posedge clk) begin
    mon_rd = M_req && M_grant && !M_wr;
    mon_rs = reset;
    #1;
    if (mon_rs) begin
      last_din = 32'h0;
    end else if (mon_rd) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL read_unexpected: read access with no expected data at %0t", $time);
      end else begin
        last_din = exp_q.pop_front();
      end
    end
    check(mon_rd ? "read_data" : "din_hold", M_din, last_din);
  end

  initial begin
    int a, sel;
    logic [31:0] d;
    // Reset state
    tick(1'b1, 1'b0, 1'b0, 0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 0, 32'h0);
    // Grant timing: request, hold, release
    tick(1'b0, 1'b0, 1'b0, 0, 32'h0);
    repeat (4) rd('h40);
    tick(1'b0, 1'b0, 1'b0, 'h40, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 'h40, 32'h0);
    // Preload the whole RAM so every later read is defined
    acquire();
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    // Write / readback
    wr(0, 32'h5); wr(1, 32'h0); wr(2, 32'h7); wr(3, 32'hFF);
    for (int i = 0; i < 4; i++) rd(i);
    // Watermark interrupt
    wr('h4C, 32'h0); wr('h4A, 32'h3); wr('h4B, 32'h1);
    wr(10, 32'h11); wr(11, 32'h22); wr(12, 32'h33);
    rd('h40); rd('h40);
    wr('h4C, 32'h0);
    rd('h40); rd('h40);
    // Out-of-range and ungranted writes
    wr('h7F, 32'hDEAD); rd('h7F); rd('h40);
    tick(1'b0, 1'b0, 1'b1, 5, 32'h1234);
    tick(1'b0, 1'b0, 1'b1, 5, 32'h5678);
    acquire(); rd(5);
    // Saturation (keeps 0x00..0x07 intact)
    for (int i = 0; i < 300; i++) wr($urandom_range(8, DEPTH - 1), $urandom);
    rd('h40);
    // Reset mid-tenure, request held across it
    tick(1'b1, 1'b1, 1'b0, 'h40, 32'h0);
    acquire();
    rd(2); rd('h40); rd('h4A); rd('h4B);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 11);
      d   = $urandom;
      if (sel < 6) a = $urandom_range(0, DEPTH - 1);
      else if (sel == 6) a = 'h40;
      else if (sel == 7) begin a = 'h4A; d = 32'($urandom_range(0, 40)); end
      else if (sel == 8) a = 'h4B;
      else if (sel == 9) a = 'h4C;
      else a = $urandom_range(DEPTH, 255);
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0),
           $urandom_range(0, 1), a, d);
    end
    tick(1'b0, 1'b0, 1'b0, 0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 0, 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
